led_scan_ctrl: RTL

LED_SCAN_CTRL -- requirements
Module: led_scan_ctrl

---
 rtl/led_scan_ctrl.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/led_scan_ctrl.sv
// -----------------------------------------------------------------------------
// led_scan_ctrl
//
// Purpose:
//   Row-scanning controller for an 8x8 multiplexed LED matrix. Two 8x8-bit
//   frame buffers are held on chip. The front buffer is displayed one row at
//   a time while the host writes the back buffer. A swap request is held
//   pending and applied only at the end of a frame, so a half-updated image
//   is never shown. Before each row is driven there is a dead-time gap
//   during which the decoder is disabled and the columns are off. This
//   avoids ghosting while the row lines settle.
//
// Parameters:
//   DWELL_CYCLES : clocks each row is driven (1..65535)
//   BLANK_CYCLES : clocks of dead time before each row (1..255)
//
// Ports:
//   clk_i          in   1  clock, rising edge
//   rst_i          in   1  synchronous active-high reset
//   scan_en_i      in   1  level enable for scanning
//   wr_en_i        in   1  back-buffer row write strobe
//   wr_row_i       in   3  back-buffer row to write
//   wr_data_i      in   8  column pattern for the written row
//   swap_req_i     in   1  single-cycle front/back exchange request
//   row_sel_o      out  3  row index to the 3-to-8 decoder
//   decoder_en_o   out  1  decoder enable, high only while a row is driven
//   col_data_o     out  8  column drive data, active-high
//   frame_done_o   out  1  one-cycle pulse after row 7 completes
//   swap_ack_o     out  1  one-cycle pulse when a pending swap is applied
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module led_scan_ctrl #(
    parameter int unsigned DWELL_CYCLES = 1000,
    parameter int unsigned BLANK_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       scan_en_i,
    input  logic       wr_en_i,
    input  logic [2:0] wr_row_i,
    input  logic [7:0] wr_data_i,
    input  logic       swap_req_i,
    output logic [2:0] row_sel_o,
    output logic       decoder_en_o,
    output logic [7:0] col_data_o,
    output logic       frame_done_o,
    output logic       swap_ack_o
);

    localparam logic [15:0] DWELL_LAST = 16'(DWELL_CYCLES - 1);
    localparam logic [7:0]  BLANK_LAST = 8'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_row;
    logic [2:0]  w_row_next;
    logic [15:0] r_dwell_cnt;
    logic [15:0] w_dwell_next;
    logic [7:0]  r_blank_cnt;
    logic [7:0]  w_blank_next;
    logic        r_front_sel;
    logic        w_front_sel_next;
    logic        r_pending;
    logic        w_pending_next;

    // Registered outputs
    logic        r_decoder_en;
    logic [7:0]  r_col_data;
    logic        r_frame_done;
    logic        r_swap_ack;

    // Control strobes for this edge
    logic        w_frame_wrap;   // leaving the last DRIVE cycle of row 7
    logic        w_swap_now;     // front-select flips on this edge

    // Both buffers share one 16-entry array. The MSB of the index selects
    // the buffer and the low three bits select the row. Entry
    // {r_front_sel, row} is the front copy, and {~r_front_sel, row} is the
    // back copy.
    logic [7:0]  r_buf [0:15];
    logic [3:0]  w_wr_addr;
    logic [3:0]  w_rd_addr;
    logic [7:0]  w_rd_data;

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_row_next   = r_row;
        w_dwell_next = r_dwell_cnt;
        w_blank_next = r_blank_cnt;
        w_frame_wrap = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_row_next   = 3'd0;
                w_dwell_next = 16'd0;
                w_blank_next = 8'd0;
                if (scan_en_i) begin
                    w_state_next = S_BLANK;
                end
            end

            S_BLANK: begin
                if (!scan_en_i) begin
                    w_state_next = S_IDLE;
                    w_row_next   = 3'd0;
                    w_dwell_next = 16'd0;
                    w_blank_next = 8'd0;
                end else if (r_blank_cnt == BLANK_LAST) begin
                    w_state_next = S_DRIVE;
                    w_dwell_next = 16'd0;
                    w_blank_next = 8'd0;
                end else begin
                    w_blank_next = r_blank_cnt + 8'd1;
                end
            end

            S_DRIVE: begin
                if (!scan_en_i) begin
                    // An aborted frame yields no frame_done.
                    // The next enable restarts the scan from row 0.
                    w_state_next = S_IDLE;
                    w_row_next   = 3'd0;
                    w_dwell_next = 16'd0;
                    w_blank_next = 8'd0;
                end else if (r_dwell_cnt == DWELL_LAST) begin
                    w_state_next = S_BLANK;
                    // The 3-bit increment wraps from row 7 back to row 0.
                    w_row_next   = r_row + 3'd1;
                    w_dwell_next = 16'd0;
                    w_blank_next = 8'd0;
                    w_frame_wrap = (r_row == 3'd7);
                end else begin
                    w_dwell_next = r_dwell_cnt + 16'd1;
                end
            end

            default: begin
                w_state_next = S_IDLE;
                w_row_next   = 3'd0;
                w_dwell_next = 16'd0;
                w_blank_next = 8'd0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Swap handling
    // ---------------------------------------------------------------------
    // At a frame wrap, a request arriving on that same cycle counts as
    // already pending. While idle, nothing is on the display, so a pending
    // swap is applied at once.
    always_comb begin
        w_swap_now = 1'b0;
        if (r_state == S_IDLE) begin
            w_swap_now = r_pending;
        end else if (w_frame_wrap) begin
            w_swap_now = r_pending | swap_req_i;
        end

        w_front_sel_next = r_front_sel ^ w_swap_now;

        if (w_swap_now) begin
            w_pending_next = 1'b0;
        end else if (swap_req_i) begin
            w_pending_next = 1'b1;
        end else begin
            w_pending_next = r_pending;
        end
    end

    // Writes target the back buffer as it stands before this edge.
    // Reads use the front select and row that take effect after this edge,
    // so col_data_o always matches row_sel_o.
    assign w_wr_addr = {~r_front_sel, wr_row_i};
    assign w_rd_addr = {w_front_sel_next, w_row_next};
    assign w_rd_data = r_buf[w_rd_addr];

    // ---------------------------------------------------------------------
    // Sequential logic
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_row       <= 3'd0;
            r_dwell_cnt <= 16'd0;
            r_blank_cnt <= 8'd0;
            r_front_sel <= 1'b0;
            r_pending   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_row       <= w_row_next;
            r_dwell_cnt <= w_dwell_next;
            r_blank_cnt <= w_blank_next;
            r_front_sel <= w_front_sel_next;
            r_pending   <= w_pending_next;
        end
    end

    // Buffer storage. The buffers need a full clear on reset,
    // so this array is built from flops rather than block RAM.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 16; i++) begin
                r_buf[i] <= 8'd0;
            end
        end else if (wr_en_i) begin
            r_buf[w_wr_addr] <= wr_data_i;
        end
    end

    // Output registers. They are loaded from the next-state values, so
    // each output changes on the same edge as the state it describes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_decoder_en <= 1'b0;
            r_col_data   <= 8'd0;
            r_frame_done <= 1'b0;
            r_swap_ack   <= 1'b0;
        end else begin
            r_decoder_en <= (w_state_next == S_DRIVE);
            r_col_data   <= (w_state_next == S_DRIVE) ? w_rd_data : 8'd0;
            r_frame_done <= w_frame_wrap;
            r_swap_ack   <= w_swap_now;
        end
    end

    // r_row is already 0 whenever the FSM is idle.
    assign row_sel_o    = r_row;
    assign decoder_en_o = r_decoder_en;
    assign col_data_o   = r_col_data;
    assign frame_done_o = r_frame_done;
    assign swap_ack_o   = r_swap_ack;

endmodule
